// File: rtl/apb_master.sv
// APB requester: turns single host commands into SETUP/ACCESS sequences,
// returns a one-cycle response and aborts completers that stall too long.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        _PCLK,
    input  logic        _PRESET,
    input  logic        _CMD_VALID,
    output logic        _CMD_READY,
    input  logic        _CMD_WRITE,
    input  logic [31:0] _CMD_ADDR,
    input  logic [31:0] _CMD_WDATA,
    output logic        _RSP_VALID,
    output logic [31:0] _RSP_RDATA,
    output logic        _RSP_ERR,
    output logic        _RSP_TIMEOUT,
    output logic        _PSEL1,
    output logic        _PENABLE,
    output logic        _PWRITE,
    output logic [31:0] _PADDR,
    output logic [31:0] _PWDATA,
    input  logic [31:0] _PRDATA,
    input  logic        _PREADY,
    input  logic        _PSLVERR
);

    localparam int unsigned CW = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_to_q, rsp_to_d;
    logic          accept, done, abort;

    // PREADY on the abort edge wins: that transfer completes normally
    always_comb begin
        done   = (state_q == ACCESS) && _PREADY;
        abort  = (state_q == ACCESS) && !_PREADY &&
                 (TIMEOUT != 0) && (cnt_q == TO_MAX);
        accept = _CMD_VALID && _CMD_READY;
    end

    assign _CMD_READY = (state_q == IDLE) || done;

    always_ff @(posedge _PCLK or posedge _PRESET) begin
        if (_PRESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (done)       state_d = _CMD_VALID ? SETUP : IDLE;
                else if (abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);

        if (accept) begin
            paddr_d  = _CMD_ADDR;
            pwrite_d = _CMD_WRITE;
            pwdata_d = _CMD_WRITE ? _CMD_WDATA : '0;
            cnt_d    = '0;
        end else if (state_q == ACCESS && !_PREADY && cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : _PRDATA;
            rsp_err_d   = _PSLVERR;
            rsp_to_d    = 1'b0;
        end else if (abort) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_to_d    = 1'b1;
        end
    end

    assign _PSEL1       = psel_q;
    assign _PENABLE     = penable_q;
    assign _PWRITE      = pwrite_q;
    assign _PADDR       = paddr_q;
    assign _PWDATA      = pwdata_q;
    assign _RSP_VALID   = rsp_valid_q;
    assign _RSP_RDATA   = rsp_rdata_q;
    assign _RSP_ERR     = rsp_err_q;
    assign _RSP_TIMEOUT = rsp_to_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: 32-word APB completer with programmable waits,
// directed scenarios, then random transfers against a transaction model.
module tb_apb_master;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_to;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_tests;
    int n_fail;

    apb_master #(.TIMEOUT(TO)) dut (
        ._PCLK(clk),
        ._PRESET(rst),
        ._CMD_VALID(cmd_valid),
        ._CMD_READY(cmd_ready),
        ._CMD_WRITE(cmd_write),
        ._CMD_ADDR(cmd_addr),
        ._CMD_WDATA(cmd_wdata),
        ._RSP_VALID(rsp_valid),
        ._RSP_RDATA(rsp_rdata),
        ._RSP_ERR(rsp_err),
        ._RSP_TIMEOUT(rsp_to),
        ._PSEL1(psel),
        ._PENABLE(penable),
        ._PWRITE(pwrite),
        ._PADDR(paddr),
        ._PWDATA(pwdata),
        ._PRDATA(prdata),
        ._PREADY(pready),
        ._PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // completer: ready after wait_n low ACCESS cycles, never if hang
    logic [31:0] mem [32];
    int          acc_cnt;
    int          wait_n;
    bit          hang;

    always_comb begin
        pready  = psel && penable && !hang && (acc_cnt >= wait_n);
        prdata  = (paddr < 32) ? mem[paddr[4:0]] : 32'hBAD0_BAD0;
        pslverr = psel && penable && (paddr >= 32);
    end

    always @(posedge clk) begin
        if (rst) begin
            acc_cnt <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (psel && penable && pready && pwrite && paddr < 32)
                mem[paddr[4:0]] <= pwdata;
        end
    end

    logic [31:0] model_mem [32];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int w, input bit h);
        bit          exp_to;
        bit          exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          lat;
        int          ps;
        int          pe;
        int          n;
        logic [31:0] rd_hold;

        exp_to  = h || (w > TO);
        exp_lat = exp_to ? TO + 2 : w + 2;
        if (exp_to) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            exp_err = (a >= 32);
            exp_rd  = wr ? 32'h0 : ((a < 32) ? model_mem[a[4:0]] : 32'hBAD0_BAD0);
            if (wr && a < 32) model_mem[a[4:0]] = d;
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        wait_n    = w;
        hang      = h;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        ps = int'(psel);
        pe = int'(penable);
        check("paddr", paddr, a);
        check("pwdata", pwdata, wr ? d : 32'h0);
        check("pwrite", 32'(pwrite), 32'(wr));
        @(negedge clk);
        cmd_valid = 1'b0;

        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            ps += int'(psel);
            pe += int'(penable);
        end
        ps += int'(psel);
        pe += int'(penable);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_timeout", 32'(rsp_to), 32'(exp_to));
        check("psel_cycles", 32'(ps), 32'(exp_lat));
        check("penable_cycles", 32'(pe), 32'(exp_lat - 1));
        rd_hold = rsp_rdata;
        @(posedge clk);
        #1;
        check("rsp_pulse_len", 32'(rsp_valid), 32'h0);
        check("rsp_hold", rsp_rdata, rd_hold);
        hang = 1'b0;
    endtask

    task automatic b2b();
        bit          b_wr [3];
        logic [31:0] b_a [3];
        logic [31:0] b_d [3];
        int          idx;
        int          e;
        bit          started;
        bit          acc;
        int          ps_cnt;
        int          rises;
        bit          prev;
        int          rsp_n;
        int          last_e;
        int          errs;
        logic [31:0] last_rd;

        b_wr[0] = 1'b1; b_a[0] = 32'h1; b_d[0] = 32'h11;
        b_wr[1] = 1'b1; b_a[1] = 32'h2; b_d[1] = 32'h22;
        b_wr[2] = 1'b0; b_a[2] = 32'h1; b_d[2] = 32'h0;
        model_mem[1] = 32'h11;
        model_mem[2] = 32'h22;
        wait_n = 0;
        hang   = 1'b0;
        idx = 0; e = 0; started = 0; ps_cnt = 0; rises = 0; prev = 0;
        rsp_n = 0; last_e = -1; errs = 0; last_rd = '0;

        for (int c = 0; c < 30 && e <= 8; c++) begin
            @(negedge clk);
            if (idx < 3) begin
                cmd_valid = 1'b1;
                cmd_write = b_wr[idx];
                cmd_addr  = b_a[idx];
                cmd_wdata = b_d[idx];
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            acc = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                started = 1;
            end
            if (started) begin
                if (psel) ps_cnt++;
                if (psel && !prev) rises++;
                prev = psel;
                if (rsp_valid) begin
                    rsp_n++;
                    last_e  = e;
                    last_rd = rsp_rdata;
                    errs += int'(rsp_err);
                end
                e++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_psel_cycles", 32'(ps_cnt), 32'd6);
        check("b2b_psel_rises", 32'(rises), 32'd1);
        check("b2b_rsp_count", 32'(rsp_n), 32'd3);
        check("b2b_last_edge", 32'(last_e), 32'd6);
        check("b2b_last_rdata", last_rd, 32'h11);
        check("b2b_errs", 32'(errs), 32'd0);
    endtask

    task automatic reset_mid_access();
        int pulses;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h3;
        cmd_wdata = '0;
        hang      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_psel", 32'(psel), 32'h1);
        check("pre_rst_penable", 32'(penable), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_psel", 32'(psel), 32'h0);
        check("async_penable", 32'(penable), 32'h0);
        check("async_paddr", paddr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pulses += int'(rsp_valid);
        end
        check("rst_no_rsp", 32'(pulses), 32'd0);
        xfer(1'b1, 32'h9, 32'hCAFE_0009, 0, 1'b0);
        xfer(1'b0, 32'h9, 32'h0, 1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h5;
        cmd_wdata = 32'h1234_5678;
        wait_n    = 0;
        hang      = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", 32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_pwrite", 32'(pwrite), 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_flags", {30'h0, rsp_err, rsp_to}, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("no_accept_in_rst", 32'(psel), 32'h0);

        xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 0, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 3, 1'b0);
        xfer(1'b0, 32'h40, 32'h0, 0, 1'b0);
        xfer(1'b0, 32'h7, 32'h0, 0, 1'b1);
        xfer(1'b1, 32'h7, 32'h0000_0777, 0, 1'b0);
        xfer(1'b0, 32'h7, 32'h0, TO, 1'b0);
        xfer(1'b1, 32'h8, 32'h0000_0888, TO + 1, 1'b0);
        b2b();
        reset_mid_access();

        for (int t = 0; t < 60; t++) begin
            bit          wr;
            logic [31:0] a;
            int          w;
            bit          h;
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 39));
            w  = int'($urandom_range(0, 5));
            h  = ($urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            xfer(wr, a, $urandom, w, h);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that converts single-transfer host commands into compliant APB SETUP/ACCESS sequences toward one completer on select line `_PSEL1`. It waits for `_PREADY` and captures `_PRDATA`/`_PSLVERR`. It returns a one-cycle response to the host and aborts stalled transfers with a programmable timeout. It sits between test/host logic and the APB memory completer.

## Interface
- `TIMEOUT`, default 16: consecutive ACCESS cycles with `_PREADY` low before abort; 0 disables the timeout.
- `_PCLK`  in  1  sole clock; everything samples on the rising edge.
- `_PRESET`  in  1  reset, asynchronous, active-high.
- One clock; reset is asynchronous and active-high.
- `_CMD_VALID`  in  1  host transfer request.
- `_CMD_READY`  out  1  command accepted when high together with `_CMD_VALID` at a rising edge.
- `_CMD_WRITE`  in  1  1 = write, 0 = read.
- `_CMD_ADDR`  in  32  transfer address.
- `_CMD_WDATA`  in  32  write data; ignored for reads.
- `_RSP_VALID`  out  1  one-cycle completion pulse.
- `_RSP_RDATA`  out  32  read data; 0 for writes and timeouts.
- `_RSP_ERR`  out  1  `_PSLVERR` captured, or timeout.
- `_RSP_TIMEOUT`  out  1  transfer aborted by timeout; qualified by `_RSP_VALID`.
- `_PSEL1`, `_PENABLE`, `_PWRITE`  out  1  APB controls.
- `_PADDR`, `_PWDATA`  out  32  APB address and write data.
- `_PRDATA`  in  32, `_PREADY`  in  1, `_PSLVERR`  in  1  completer returns.

## Operation
- States and APB outputs:
  - IDLE: `_PSEL1`=0, `_PENABLE`=0.
  - SETUP: `_PSEL1`=1, `_PENABLE`=0.
  - ACCESS: `_PSEL1`=1, `_PENABLE`=1.
- `_CMD_READY` = (state==IDLE) | (state==ACCESS & `_PREADY`). It is combinational from state and `_PREADY`, and is low during SETUP and during a timeout abort cycle.
- IDLE -> SETUP on accept. `_PADDR`, `_PWRITE` and `_PWDATA` are registered from the command at that edge and held stable until the next accept. For reads, `_PWDATA` is loaded with 0.
- SETUP -> ACCESS unconditionally after one cycle.
- ACCESS with `_PREADY`=0: stay in ACCESS and increment the wait counter, which saturates at `TIMEOUT`.
- ACCESS with `_PREADY`=1 (completion):
  - Capture `_PSLVERR`. Capture `_PRDATA` on reads only, else 0.
  - With `_CMD_VALID`=1 in the same cycle, go to SETUP with `_PSEL1` held high (back-to-back), and load the new command.
  - Otherwise go to IDLE.
- Timeout: ACCESS has run `TIMEOUT` cycles with `_PREADY` low and `_PREADY` is still low → go to IDLE and drop `_PSEL1`/`_PENABLE`. Respond with `_RSP_ERR`=1, `_RSP_TIMEOUT`=1, `_RSP_RDATA`=0.
- The wait counter clears on every entry to SETUP.
- `_PSLVERR` is treated as an error response only. No retry; the data of an errored read is still returned as captured.
- The response has no backpressure; the host must absorb every `_RSP_VALID` pulse.

## Timing
- Reset values, applied immediately on `_PRESET` high:
  - state IDLE, wait counter 0.
  - `_PSEL1`, `_PENABLE`, `_PWRITE`, `_RSP_VALID`, `_RSP_ERR`, `_RSP_TIMEOUT` = 0.
  - `_PADDR`, `_PWDATA`, `_RSP_RDATA` = 0.
  - `_CMD_READY` = 1 while reset is held (state is IDLE), but no accept occurs during reset.
- Reset mid-transfer abandons the transfer: no response is generated, and the APB outputs drop asynchronously.
- All APB outputs and the response outputs are registered; only `_CMD_READY` is combinational.
- Latency for a command accepted at edge N:
  - SETUP cycle N..N+1, ACCESS from N+1.
  - With a zero-wait completer (`_PREADY` high at edge N+2), `_RSP_VALID` is high N+2..N+3.
  - Each wait cycle adds 1.
- Throughput: a back-to-back stream occupies 2 cycles per transfer at zero wait. `_PSEL1` never deasserts between back-to-back transfers.
- `_RSP_VALID` is high for exactly one cycle per completed or aborted transfer. The `_RSP_*` data fields hold until the next response.
- Timeout with `TIMEOUT`=T: the abort edge is T+1 edges after ACCESS entry with `_PREADY` continuously low. `_PREADY` rising on that same edge counts as a normal completion, not a timeout.

## Test plan
- Reset, then write 0xDEADBEEF to 0x4, zero-wait completer:
  - `_PSEL1` high for exactly 2 cycles, `_PENABLE` high in the 2nd.
  - `_PWDATA` = 0xDEADBEEF, `_RSP_VALID` pulse with `_RSP_ERR`=0.
- Read 0x4 after that write, with the completer inserting 3 wait cycles:
  - ACCESS lasts 4 cycles.
  - `_RSP_RDATA` = 0xDEADBEEF, response 5 cycles after accept.
- Read 0x40 from a 32-word completer that flags `_PSLVERR`: `_RSP_ERR`=1, `_RSP_TIMEOUT`=0.
- `TIMEOUT`=4, completer never raises `_PREADY`:
  - Abort after 4 ACCESS wait cycles.
  - `_RSP_ERR`=1, `_RSP_TIMEOUT`=1, `_RSP_RDATA`=0, state back to IDLE, next command accepted.
- Three back-to-back commands (write 0x1→0x11, write 0x2→0x22, read 0x1):
  - `_PSEL1` stays high 6 cycles.
  - Three responses, the last with `_RSP_RDATA`=0x11.
- `_PRESET` pulsed during ACCESS:
  - All APB outputs drop to 0 without waiting for a clock.
  - No `_RSP_VALID`; the first command after release completes normally.
